// File: rtl/guess_round_ctrl.sv
// Purpose: round/guess/timer control for the number-guessing game; hints, counters and win/lose status.
// Latency: a confirmed guess updates hint/guesses_left/invalid_guess one cycle later; start/confirm enter LOAD next cycle.
// Backpressure: none; start and guess_valid are single-cycle pulses, ignored in states that cannot use them.
module guess_round_ctrl #(
  parameter int MAX_DIGITS = 3,
  parameter int NUM_ROUNDS = 3,
  parameter int MAX_WRONG  = 5,
  parameter int ROUND_TIME = 99,
  parameter int TIME_W     = 7,
  parameter int TICK_DIV   = 50000000,
  localparam int BUS_W     = 4 * MAX_DIGITS,
  localparam int GL_W      = $clog2(MAX_WRONG + 1),
  localparam int RND_W     = $clog2(NUM_ROUNDS + 1),
  localparam int AD_W      = $clog2(MAX_DIGITS + 1),
  localparam int PS_W      = $clog2(TICK_DIV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BUS_W-1:0]  secret_in,
  input  logic [BUS_W-1:0]  guess_bcd,
  input  logic              guess_valid,
  output logic [1:0]        hint,
  output logic              invalid_guess,
  output logic [GL_W-1:0]   guesses_left,
  output logic [RND_W-1:0]  round,
  output logic [AD_W-1:0]   active_digits,
  output logic [TIME_W-1:0] timer,
  output logic [1:0]        win_lose,
  output logic              round_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_ROUND_WIN,
    S_GAME_WIN,
    S_GAME_LOSE
  } state_t;

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;
  localparam logic [1:0] HINT_OK   = 2'b11;

  state_t state_q, state_d;

  logic [BUS_W-1:0]  secret_q;
  logic [BUS_W-1:0]  secret_clean;
  logic [BUS_W-1:0]  guess_masked;
  logic [1:0]        hint_q;
  logic              invalid_q;
  logic [GL_W-1:0]   guesses_left_q;
  logic [RND_W-1:0]  round_q;
  logic [AD_W-1:0]   active_d;
  logic [TIME_W-1:0] timer_q;
  logic [PS_W-1:0]   presc_q;

  logic guess_bad;
  logic guess_eq;
  logic guess_lt;
  logic guess_ok;
  logic tick_wrap;
  logic time_up;
  logic last_wrong;
  logic round_last;

  // Digits in play follow the round number directly, saturating at the bus width.
  always_comb begin
    if (int'(round_q) > MAX_DIGITS) begin
      active_d = AD_W'(MAX_DIGITS);
    end else begin
      active_d = AD_W'(round_q);
    end
  end

  // Mask inactive digits on both buses, flag bad guess digits and clamp bad secret digits to 9.
  always_comb begin
    secret_clean = '0;
    guess_masked = '0;
    guess_bad    = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < int'(active_d)) begin
        guess_masked[4*i +: 4] = guess_bcd[4*i +: 4];
        if (guess_bcd[4*i +: 4] > 4'd9) begin
          guess_bad = 1'b1;
        end
        secret_clean[4*i +: 4] = (secret_in[4*i +: 4] > 4'd9) ? 4'd9 : secret_in[4*i +: 4];
      end
    end
  end

  // Packed BCD with zeroed upper digits orders the same as the numbers it encodes.
  assign guess_eq   = (guess_masked == secret_q);
  assign guess_lt   = (guess_masked < secret_q);
  assign guess_ok   = guess_valid && !guess_bad;
  assign tick_wrap  = (presc_q == PS_W'(TICK_DIV - 1));
  assign time_up    = tick_wrap && (timer_q <= TIME_W'(1));
  assign last_wrong = (guesses_left_q <= GL_W'(1));
  assign round_last = (round_q == RND_W'(NUM_ROUNDS));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a correct guess beats a simultaneous timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (guess_ok && guess_eq) begin
          state_d = round_last ? S_GAME_WIN : S_ROUND_WIN;
        end else if ((guess_ok && last_wrong) || time_up) begin
          state_d = S_GAME_LOSE;
        end
      end
      S_ROUND_WIN: begin
        if (guess_valid) state_d = S_LOAD;
      end
      S_GAME_WIN, S_GAME_LOSE: begin
        if (start) state_d = S_LOAD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    win_lose   = 2'b00;
    round_done = 1'b0;
    case (state_q)
      S_ROUND_WIN: round_done = 1'b1;
      S_GAME_WIN:  win_lose   = 2'b01;
      S_GAME_LOSE: win_lose   = 2'b10;
      default: begin
        win_lose   = 2'b00;
        round_done = 1'b0;
      end
    endcase
  end

  // Round datapath: secret latch, guess scoring, guess budget and the prescaled round timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      secret_q       <= '0;
      hint_q         <= HINT_NONE;
      invalid_q      <= 1'b0;
      guesses_left_q <= '0;
      round_q        <= '0;
      timer_q        <= '0;
      presc_q        <= '0;
    end else begin
      invalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) round_q <= RND_W'(1);
        end
        S_LOAD: begin
          secret_q       <= secret_clean;
          guesses_left_q <= GL_W'(MAX_WRONG);
          timer_q        <= TIME_W'(ROUND_TIME);
          hint_q         <= HINT_NONE;
          presc_q        <= '0;
        end
        S_PLAY: begin
          if (tick_wrap) begin
            presc_q <= '0;
            if (timer_q != '0) timer_q <= timer_q - TIME_W'(1);
          end else begin
            presc_q <= presc_q + PS_W'(1);
          end
          if (guess_valid) begin
            if (guess_bad) begin
              invalid_q <= 1'b1;
            end else if (guess_eq) begin
              hint_q <= HINT_OK;
            end else begin
              hint_q <= guess_lt ? HINT_LOW : HINT_HIGH;
              if (guesses_left_q != '0) guesses_left_q <= guesses_left_q - GL_W'(1);
            end
          end
        end
        S_ROUND_WIN: begin
          if (guess_valid) round_q <= round_q + RND_W'(1);
        end
        S_GAME_WIN, S_GAME_LOSE: begin
          if (start) round_q <= RND_W'(1);
        end
        default: begin
          round_q <= '0;
        end
      endcase
    end
  end

  assign hint          = hint_q;
  assign invalid_guess = invalid_q;
  assign guesses_left  = guesses_left_q;
  assign round         = round_q;
  assign active_digits = active_d;
  assign timer         = timer_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl with a small game configuration.
// Expected output snapshots are queued as stimulus is applied and checked once the DUT responds.
// Field value -1 in an expectation means that field is not checked at that point.
module tb_guess_round_ctrl;

  localparam int MAX_DIGITS = 3;
  localparam int NUM_ROUNDS = 3;
  localparam int MAX_WRONG  = 3;
  localparam int ROUND_TIME = 5;
  localparam int TIME_W     = 7;
  localparam int TICK_DIV   = 4;
  localparam int BUS_W      = 4 * MAX_DIGITS;
  localparam int GL_W       = $clog2(MAX_WRONG + 1);
  localparam int RND_W      = $clog2(NUM_ROUNDS + 1);
  localparam int AD_W       = $clog2(MAX_DIGITS + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [BUS_W-1:0]  secret_in;
  logic [BUS_W-1:0]  guess_bcd;
  logic              guess_valid;
  logic [1:0]        hint;
  logic              invalid_guess;
  logic [GL_W-1:0]   guesses_left;
  logic [RND_W-1:0]  round;
  logic [AD_W-1:0]   active_digits;
  logic [TIME_W-1:0] timer;
  logic [1:0]        win_lose;
  logic              round_done;

  guess_round_ctrl #(
    .MAX_DIGITS (MAX_DIGITS),
    .NUM_ROUNDS (NUM_ROUNDS),
    .MAX_WRONG  (MAX_WRONG),
    .ROUND_TIME (ROUND_TIME),
    .TIME_W     (TIME_W),
    .TICK_DIV   (TICK_DIV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .secret_in     (secret_in),
    .guess_bcd     (guess_bcd),
    .guess_valid   (guess_valid),
    .hint,
    .invalid_guess (invalid_guess),
    .guesses_left  (guesses_left),
    .round         (round),
    .active_digits (active_digits),
    .timer         (timer),
    .win_lose      (win_lose),
    .round_done    (round_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    hint;
    int    inv;
    int    gl;
    int    rnd;
    int    ad;
    int    tmr;
    int    wl;
    int    rd;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int h, input int inv, input int gl, input int rnd,
                      input int ad, input int tmr, input int wl, input int rd);
    exp_t e;
    e.tag = tag; e.hint = h; e.inv = inv; e.gl = gl; e.rnd = rnd;
    e.ad = ad; e.tmr = tmr; e.wl = wl; e.rd = rd;
    sbq.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input int e);
    if (e >= 0) begin
      tests++;
      assert (obs === 32'(e))
      else begin
        fails++;
        $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, e);
      end
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sbq.pop_front();
      cmp(e.tag, "hint",          {30'b0, hint},      e.hint);
      cmp(e.tag, "invalid_guess", 32'(invalid_guess), e.inv);
      cmp(e.tag, "guesses_left",  32'(guesses_left),  e.gl);
      cmp(e.tag, "round",         32'(round),         e.rnd);
      cmp(e.tag, "active_digits", 32'(active_digits), e.ad);
      cmp(e.tag, "timer",         32'(timer),         e.tmr);
      cmp(e.tag, "win_lose",      32'(win_lose),      e.wl);
      cmp(e.tag, "round_done",    32'(round_done),    e.rd);
    end
  endtask

  // Queue an expectation, let n edges pass, then check.
  task automatic expect_after(input int n, input string tag, input int h, input int inv, input int gl,
                              input int rnd, input int ad, input int tmr, input int wl, input int rd);
    push(tag, h, inv, gl, rnd, ad, tmr, wl, rd);
    repeat (n) tick();
    pop_check();
  endtask

  // One-cycle confirm pulse with a guess value.
  task automatic guess(input logic [BUS_W-1:0] g, input string tag, input int h, input int inv,
                       input int gl, input int rnd, input int ad, input int tmr, input int wl, input int rd);
    guess_bcd   = g;
    guess_valid = 1'b1;
    push(tag, h, inv, gl, rnd, ad, tmr, wl, rd);
    tick();
    guess_valid = 1'b0;
    pop_check();
  endtask

  task automatic pulse_start(input string tag, input int h, input int inv, input int gl, input int rnd,
                             input int ad, input int tmr, input int wl, input int rd);
    start = 1'b1;
    push(tag, h, inv, gl, rnd, ad, tmr, wl, rd);
    tick();
    start = 1'b0;
    pop_check();
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    guess_valid = 1'b0;
    guess_bcd   = '0;
    secret_in   = 12'h127;
    tick();
    tick();
    expect_after(0, "reset_init", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Reset in the middle of a round.
    pulse_start("t1_start", 0, 0, 0, 1, 1, 0, 0, 0);
    expect_after(1, "t1_play", 0, 0, 3, 1, 1, 5, 0, 0);
    guess(12'h005, "t1_low", 1, 0, 2, 1, 1, 5, 0, 0);
    expect_after(8, "t1_mid", 1, 0, 2, 1, 1, 3, 0, 0);
    rst = 1'b1;
    expect_after(1, "t1_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    pulse_start("t1_restart", 0, 0, 0, 1, 1, 0, 0, 0);
    expect_after(1, "t1_load", 0, 0, 3, 1, 1, 5, 0, 0);

    // Round 1: secret 0x127 masked to 7.
    guess(12'h005, "t2_g5", 1, 0, 2, 1, 1, 5, 0, 0);
    guess(12'h009, "t2_g9", 2, 0, 1, 1, 1, 5, 0, 0);
    guess(12'h007, "t2_g7", 3, 0, 1, 1, 1, 5, 0, 1);
    expect_after(3, "t2_hold", 3, 0, 1, 1, 1, 5, 0, 1);
    guess(12'h000, "t2_confirm", 3, 0, 1, 2, 2, 5, 0, 0);
    expect_after(1, "t2_load", 0, 0, 3, 2, 2, 5, 0, 0);

    // Round 2 (secret 0x027): exhaust the guess budget.
    guess(12'h010, "t3_w1", 1, 0, 2, 2, 2, 5, 0, 0);
    guess(12'h010, "t3_w2", 1, 0, 1, 2, 2, 5, 0, 0);
    guess(12'h010, "t3_w3", 1, 0, 0, 2, 2, 5, 2, 0);
    guess(12'h027, "t3_ignored", 1, 0, 0, 2, 2, 5, 2, 0);
    expect_after(4, "t3_hold", 1, 0, 0, 2, 2, 5, 2, 0);
    pulse_start("t3_restart", 1, 0, 0, 1, 1, 5, 0, 0);
    expect_after(1, "t4_entry", 0, 0, 3, 1, 1, 5, 0, 0);

    // Timer runs out with no guesses: one second per 4 cycles.
    for (int k = 1; k < 20; k++) begin
      expect_after(1, "t4_run", 0, 0, 3, 1, 1, 5 - k / 4, 0, 0);
    end
    expect_after(1, "t4_expire", 0, 0, 3, 1, 1, 0, 2, 0);
    expect_after(4, "t4_no_underflow", 0, 0, 3, 1, 1, 0, 2, 0);

    // Invalid digit, masking of inactive digits and clamping of the secret.
    pulse_start("t5_start", 0, 0, 3, 1, 1, 0, 0, 0);
    expect_after(1, "t5_play", 0, 0, 3, 1, 1, 5, 0, 0);
    guess(12'h007, "t5_r1win", 3, 0, 3, 1, 1, 5, 0, 1);
    secret_in = 12'h0B3;
    guess(12'h000, "t5_confirm", 3, 0, 3, 2, 2, 5, 0, 0);
    expect_after(1, "t5_load", 0, 0, 3, 2, 2, 5, 0, 0);
    guess(12'h010, "t5_low", 1, 0, 2, 2, 2, 5, 0, 0);
    guess(12'h0A3, "t5_invalid", 1, 1, 2, 2, 2, 5, 0, 0);
    expect_after(1, "t5_pulse_end", 1, 0, 2, 2, 2, 5, 0, 0);
    guess(12'h593, "t5_masked_clamped", 3, 0, 2, 2, 2, 4, 0, 1);

    // Round 3: confirm held through LOAD, start ignored, correct guess on expiry.
    secret_in = 12'h456;
    expect_after(2, "t6_frozen", 3, 0, 2, 2, 2, 4, 0, 1);
    guess_bcd   = 12'h000;
    guess_valid = 1'b1;
    push("t6_confirm", 3, 0, 2, 3, 3, 4, 0, 0);
    tick();
    pop_check();
    push("t6_load_ignored", 0, 0, 3, 3, 3, 5, 0, 0);
    tick();
    guess_valid = 1'b0;
    pop_check();
    pulse_start("t6_start_ignored", 0, 0, 3, 3, 3, 5, 0, 0);
    expect_after(18, "t6_last_second", 0, 0, 3, 3, 3, 1, 0, 0);
    guess(12'h456, "t6_win_at_expiry", 3, 0, 3, 3, 3, 0, 1, 0);
    expect_after(3, "t6_hold", 3, 0, 3, 3, 3, 0, 1, 0);
    pulse_start("t6_restart", 3, 0, 3, 1, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
